sva_result_collector: RTL
=========================

// Module: sva_result_collector
// PURPOSE
//   Downstream stage of the per-gclk SVA evaluation FSM. Consumes its per-evaluation
//   result (succ / fail / lazy_succ), keeps saturating result counters, and latches the
//   gclk period of the first failure. Pushes every result event, stamped with its gclk
//   period, into a small FIFO. The FIFO is drained by the report/logging stage over valid/ready.
// PARAMETERS
//   CNT_WIDTH     16  width of each saturating result counter
//   TS_WIDTH      16  width of gclk period stamp (wraps)
//   FIFO_DEPTH    8   event FIFO entries; power of 2, >= 2
//   STOP_ON_FAIL  0   1: after the first fail, stop recording until clr
// PORTS
//   sys_clk         in   1          system clock; the only clock
//   sys_rst_n       in   1          asynchronous, active-low reset
//   clr             in   1          synchronous clear of all state
//   gclk_tick       in   1          one-sys_clk pulse per user-clock posedge
//   res_valid       in   1          strobe: succ/fail/lazy_succ valid this cycle
//   succ            in   1          evaluation reached SEND
//   fail            in   1          evaluation had no legal transition
//   lazy_succ       in   1          evaluation reached SLAZY
//   evt_valid       out  1          FIFO head valid
//   evt_ready       in   1          consumer accepts head
//   evt_data        out  2+TS_WIDTH {kind[1:0], period[TS_WIDTH-1:0]}
//   succ_cnt        out  CNT_WIDTH  saturating count of succ events
//   fail_cnt        out  CNT_WIDTH  saturating count of fail events
//   lazy_cnt        out  CNT_WIDTH  saturating count of lazy events
//   first_fail_vld  out  1          sticky: a fail has been recorded
//   first_fail_per  out  TS_WIDTH   period stamp of the first fail
//   overflow        out  1          sticky: an event was dropped because the FIFO was full
//   halted          out  1          FSM is in HALTED
// BEHAVIOUR
//   Reset (sys_rst_n=0, async) or clr=1 (sync):
//     - all counters, period, FIFO pointers, first_fail_* and overflow go to 0.
//     - evt_valid=0, evt_data=0, FSM=RUN.
//     - clr has priority over every other input in the same cycle.
//   Period counter:
//     - increments by 1 on gclk_tick, wrapping at 2^TS_WIDTH.
//     - An event is stamped with the pre-increment value in its cycle.
//   Event decode, only when res_valid=1 and FSM=RUN:
//     - Priority fail > succ > lazy_succ; exactly one event is recorded per strobe.
//     - res_valid with no flag set records nothing.
//     - Flags without res_valid are ignored.
//   Counters:
//     - Per kind +1, saturating at 2^CNT_WIDTH-1 (no wrap).
//     - Counters count dropped events too.
//     - Visible in cycle N+1 for a strobe in cycle N.
//   First fail:
//     - On the first recorded fail, first_fail_vld=1 and first_fail_per=stamp.
//     - Both hold until reset or clr.
//   FIFO:
//     - Push on a recorded event. evt_valid/evt_data are registered: an event pushed into
//       an empty FIFO at cycle N appears at N+1.
//     - Pop when evt_valid & evt_ready.
//     - Full and no pop in the same cycle: the event is dropped and overflow=1 (sticky).
//     - Full with a simultaneous pop: the push is accepted.
//     - Empty: evt_valid=0; evt_ready is ignored.
//     - evt_data is held stable while evt_valid & !evt_ready.
//     - Pointers carry an extra wrap bit to separate full from empty.
//   FSM (RUN, HALTED):
//     - RUN -> HALTED in the cycle after a recorded fail, only when STOP_ON_FAIL=1.
//     - In HALTED: no counting and no pushes; the FIFO keeps draining.
//     - HALTED -> RUN only on clr or reset.
//     - With STOP_ON_FAIL=0 the FSM stays in RUN.
// STRUCTURE
//   Package sva_result_pkg holds:
//     - sva_evt_kind_t enum logic[1:0]: EVT_NONE=0, EVT_SUCC=1, EVT_FAIL=2, EVT_LAZY=3.
//     - sva_evt_t packed struct {kind, period}.
//     - collector_fsm_t enum: RUN, HALTED.
//   Sub-module sva_evt_fifo: sync FIFO with registered output, DEPTH/WIDTH params,
//   push/full, pop/empty, level. The decode, counters, period and FSM live in the top.
// TESTING
//   1 Reset, then 3 ticks, then res_valid+succ -> evt_data={EVT_SUCC,3} at N+1; succ_cnt=1.
//   2 Strobe with fail+succ+lazy together -> one EVT_FAIL; fail_cnt=1, succ_cnt=0,
//     first_fail_vld=1; a later fail leaves first_fail_per unchanged.
//   3 evt_ready=0, 9 succ strobes, DEPTH=8 -> 8 held, overflow=1, succ_cnt=9.
//     Full + pop + push in one cycle -> level stays 8 and no extra overflow.
//   4 CNT_WIDTH=4, 20 lazy strobes -> lazy_cnt sticks at 15.
//   5 STOP_ON_FAIL=1, fail then 2 succ -> halted=1, succ_cnt=0, FIFO holds 1 entry.
//     clr -> all state 0 and halted=0.
//   6 sys_rst_n low mid-stream with 4 entries queued -> evt_valid=0 and all counters 0
//     immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sva_result_pkg.sv
// rtl/sva_result_pkg.sv - shared types and defaults for the SVA result collector
package sva_result_pkg;

  localparam int SVA_CNT_WIDTH  = 16;
  localparam int SVA_TS_WIDTH   = 16;
  localparam int SVA_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_SUCC = 2'd1,
    EVT_FAIL = 2'd2,
    EVT_LAZY = 2'd3
  } sva_evt_kind_t;

  typedef struct packed {
    sva_evt_kind_t             kind;
    logic [SVA_TS_WIDTH-1:0]   period;
  } sva_evt_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } collector_fsm_t;

  // A fail outranks everything, so a broken evaluation is never reported as a success.
  function automatic sva_evt_kind_t decode_evt(input logic f, input logic s, input logic l);
    if (f)      return EVT_FAIL;
    else if (s) return EVT_SUCC;
    else if (l) return EVT_LAZY;
    else        return EVT_NONE;
  endfunction

endpackage

// File: rtl/sva_evt_if.sv
// rtl/sva_evt_if.sv - valid/ready event stream from the collector to the report stage
interface sva_evt_if #(
  parameter int W = 2 + sva_result_pkg::SVA_TS_WIDTH
);
  logic         evt_valid;
  logic         evt_ready;
  logic [W-1:0] evt_data;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/sva_evt_fifo.sv
// rtl/sva_evt_fifo.sv - synchronous event FIFO with wrap-bit pointers and registered storage
module sva_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 18
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic                       full_o,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  // When full, a same-cycle pop frees the slot the write lands in.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/sva_result_collector.sv
// rtl/sva_result_collector.sv - counts SVA evaluation results, stamps and queues them as events
module sva_result_collector
  import sva_result_pkg::*;
#(
  parameter int CNT_WIDTH    = SVA_CNT_WIDTH,
  parameter int TS_WIDTH     = SVA_TS_WIDTH,
  parameter int FIFO_DEPTH   = SVA_FIFO_DEPTH,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 clr,
  input  logic                 gclk_tick,
  input  logic                 res_valid,
  input  logic                 succ,
  input  logic                 fail,
  input  logic                 lazy_succ,
  sva_evt_if.master            evt,
  output logic [CNT_WIDTH-1:0] succ_cnt,
  output logic [CNT_WIDTH-1:0] fail_cnt,
  output logic [CNT_WIDTH-1:0] lazy_cnt,
  output logic                 first_fail_vld,
  output logic [TS_WIDTH-1:0]  first_fail_per,
  output logic                 overflow,
  output logic                 halted
);

  localparam int EW = 2 + TS_WIDTH;

  collector_fsm_t state_q, state_d;
  sva_evt_kind_t  evt_kind;
  logic           run_en, rec, rec_fail, drop;
  logic           fifo_full, fifo_empty, fifo_pop;
  logic [EW-1:0]  fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic           unused_level;

  logic [TS_WIDTH-1:0]  period_q, period_d, ffp_q, ffp_d;
  logic [CNT_WIDTH-1:0] succ_q, succ_d, fail_q, fail_d, lazy_q, lazy_d;
  logic                 ffv_q, ffv_d, ovf_q, ovf_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign evt_kind = decode_evt(fail, succ, lazy_succ);
  assign rec      = res_valid && run_en && (evt_kind != EVT_NONE);
  assign rec_fail = rec && (evt_kind == EVT_FAIL);
  assign fifo_pop = !fifo_empty && evt.evt_ready;
  assign drop     = rec && fifo_full && !fifo_pop;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  state_q <= RUN;
    else if (clr)    state_q <= RUN;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == RUN) && (STOP_ON_FAIL != 0) && rec_fail) state_d = HALTED;
  end

  always_comb begin
    run_en = (state_q == RUN);
    halted = (state_q == HALTED);
  end

  // Dropped events are still counted; only the FIFO entry is lost.
  always_comb begin
    period_d = gclk_tick ? period_q + 1'b1 : period_q;
    succ_d   = succ_q;
    fail_d   = fail_q;
    lazy_d   = lazy_q;
    if (rec) begin
      case (evt_kind)
        EVT_SUCC: succ_d = sat_inc(succ_q);
        EVT_FAIL: fail_d = sat_inc(fail_q);
        EVT_LAZY: lazy_d = sat_inc(lazy_q);
        default:  ;
      endcase
    end
    ffv_d = ffv_q | rec_fail;
    ffp_d = (rec_fail && !ffv_q) ? period_q : ffp_q;
    ovf_d = ovf_q | drop;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      period_q <= '0; ffp_q <= '0;
      succ_q   <= '0; fail_q <= '0; lazy_q <= '0;
      ffv_q    <= 1'b0; ovf_q <= 1'b0;
    end else if (clr) begin
      period_q <= '0; ffp_q <= '0;
      succ_q   <= '0; fail_q <= '0; lazy_q <= '0;
      ffv_q    <= 1'b0; ovf_q <= 1'b0;
    end else begin
      period_q <= period_d; ffp_q <= ffp_d;
      succ_q   <= succ_d;   fail_q <= fail_d; lazy_q <= lazy_d;
      ffv_q    <= ffv_d;    ovf_q <= ovf_d;
    end
  end

  sva_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .clr_i   (clr),
    .push_i  (rec),
    .data_i  ({evt_kind, period_q}),
    .full_o  (fifo_full),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign unused_level   = ^fifo_level;
  assign evt.evt_valid  = !fifo_empty;
  assign evt.evt_data   = fifo_dout;
  assign succ_cnt       = succ_q;
  assign fail_cnt       = fail_q;
  assign lazy_cnt       = lazy_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_per = ffp_q;
  assign overflow       = ovf_q;

endmodule
